range_tracker: RTL and testbench

Streaming min/max tracker for 4-bit samples, placed directly downstream of the 4-bit magnitude comparator stage. It consumes a valid-qualified sample stream and compares each sample against stored extremes using the comparator's eq/gt/lt decision. It maintains the running minimum, running maximum, span and a saturating sample count, and pulses an event flag whenever an extreme is replaced. A small FSM tracks empty, tracking and count-saturated conditions.

---
 rtl/range_tracker_pkg.sv | 17 +
 rtl/mag_comp4.sv | 25 ++
 rtl/range_tracker.sv | 162 ++++++++++++++++
 tb/tb_range_tracker.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/range_tracker_pkg.sv
// ---------------------------------------------------------------------------
// range_tracker_pkg
// Shared definitions for the streaming min/max tracker:
//   SAMPLE_W - width of one unsigned sample
//   state_t  - tracker FSM encoding (EMPTY, TRACK, SAT)
// ---------------------------------------------------------------------------
package range_tracker_pkg;

   localparam int SAMPLE_W = 4;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      TRACK = 2'd1,
      SAT   = 2'd2
   } state_t;

endpackage : range_tracker_pkg

// File: rtl/mag_comp4.sv
// ---------------------------------------------------------------------------
// mag_comp4
// 4-bit unsigned magnitude comparator. Exactly one of eq/gt/lt is high for
// every input pair.
// Ports:
//   a, b  - unsigned operands
//   eq    - a == b
//   gt    - a >  b
//   lt    - a <  b
// ---------------------------------------------------------------------------
module mag_comp4
   import range_tracker_pkg::*;
(
   input  logic [SAMPLE_W-1:0] a,
   input  logic [SAMPLE_W-1:0] b,
   output logic                eq,
   output logic                gt,
   output logic                lt
);

   assign eq = (a == b);
   assign gt = (a >  b);
   assign lt = (a <  b);

endmodule : mag_comp4

// File: rtl/range_tracker.sv
// ---------------------------------------------------------------------------
// range_tracker
// Streaming min/max tracker for unsigned 4-bit samples. Each accepted sample
// is compared against the registered extremes; the extremes, a saturating
// sample count and one-cycle replacement pulses are updated one cycle later.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   clr          - synchronous clear back to the empty state (beats in_valid)
//   in_valid     - in_data carries a sample this cycle
//   in_data      - unsigned sample
//   min_val      - running minimum
//   max_val      - running maximum
//   span         - max_val - min_val
//   range_valid  - at least one sample held since reset/clr
//   new_min      - one-cycle pulse, min_val replaced
//   new_max      - one-cycle pulse, max_val replaced
//   count        - accepted samples, saturating at all-ones
//   cnt_sat      - count is at all-ones
// ---------------------------------------------------------------------------
module range_tracker
   import range_tracker_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                in_valid,
   input  logic [SAMPLE_W-1:0] in_data,
   output logic [SAMPLE_W-1:0] min_val,
   output logic [SAMPLE_W-1:0] max_val,
   output logic [SAMPLE_W-1:0] span,
   output logic                range_valid,
   output logic                new_min,
   output logic                new_max,
   output logic [CNT_W-1:0]    count,
   output logic                cnt_sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Comparator slot 0 checks the sample against min, slot 1 against max.
   localparam int CMP_MIN = 0;
   localparam int CMP_MAX = 1;

   state_t              state_reg;
   logic [SAMPLE_W-1:0] min_reg;
   logic [SAMPLE_W-1:0] max_reg;
   logic                range_valid_reg;
   logic                new_min_reg;
   logic                new_max_reg;
   logic [CNT_W-1:0]    count_reg;
   logic                cnt_sat_reg;

   logic [SAMPLE_W-1:0] cmp_ref [2];
   logic [1:0]          cmp_eq;
   logic [1:0]          cmp_gt;
   logic [1:0]          cmp_lt;
   logic [CNT_W-1:0]    count_next;
   logic                accept;

   assign cmp_ref[CMP_MIN] = min_reg;
   assign cmp_ref[CMP_MAX] = max_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cmp
         mag_comp4 u_cmp (
            .a  (in_data),
            .b  (cmp_ref[gi]),
            .eq (cmp_eq[gi]),
            .gt (cmp_gt[gi]),
            .lt (cmp_lt[gi])
         );
      end
   endgenerate

   // Only "below min" and "above max" drive updates; equality and the
   // opposite-direction results mean "hold", which is the default.
   logic unused_cmp;
   assign unused_cmp = ^{cmp_eq, cmp_gt[CMP_MIN], cmp_lt[CMP_MAX]};

   assign accept     = in_valid && !clr;
   assign count_next = count_reg + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= EMPTY;
         min_reg         <= '0;
         max_reg         <= '0;
         range_valid_reg <= 1'b0;
         new_min_reg     <= 1'b0;
         new_max_reg     <= 1'b0;
         count_reg       <= '0;
         cnt_sat_reg     <= 1'b0;
      end else if (clr) begin
         state_reg       <= EMPTY;
         min_reg         <= '0;
         max_reg         <= '0;
         range_valid_reg <= 1'b0;
         new_min_reg     <= 1'b0;
         new_max_reg     <= 1'b0;
         count_reg       <= '0;
         cnt_sat_reg     <= 1'b0;
      end else begin
         // Pulses are single-cycle unless re-asserted below.
         new_min_reg <= 1'b0;
         new_max_reg <= 1'b0;
         if (accept) begin
            case (state_reg)
               EMPTY: begin
                  min_reg         <= in_data;
                  max_reg         <= in_data;
                  new_min_reg     <= 1'b1;
                  new_max_reg     <= 1'b1;
                  range_valid_reg <= 1'b1;
                  count_reg       <= CNT_ONE;
                  if (CNT_ONE == CNT_MAX) begin
                     state_reg   <= SAT;
                     cnt_sat_reg <= 1'b1;
                  end else begin
                     state_reg   <= TRACK;
                  end
               end
               TRACK, SAT: begin
                  if (cmp_lt[CMP_MIN]) begin
                     min_reg     <= in_data;
                     new_min_reg <= 1'b1;
                  end
                  if (cmp_gt[CMP_MAX]) begin
                     max_reg     <= in_data;
                     new_max_reg <= 1'b1;
                  end
                  // Count stops at all-ones; SAT just keeps tracking extremes.
                  if (state_reg == TRACK) begin
                     count_reg <= count_next;
                     if (count_next == CNT_MAX) begin
                        state_reg   <= SAT;
                        cnt_sat_reg <= 1'b1;
                     end
                  end
               end
               default: begin
                  state_reg <= EMPTY;
               end
            endcase
         end
      end
   end

   assign min_val     = min_reg;
   assign max_val     = max_reg;
   // Both extremes are zero while empty, so the difference is zero there too.
   assign span        = max_reg - min_reg;
   assign range_valid = range_valid_reg;
   assign new_min     = new_min_reg;
   assign new_max     = new_max_reg;
   assign count       = count_reg;
   assign cnt_sat     = cnt_sat_reg;

endmodule : range_tracker

// File: tb/tb_range_tracker.sv
module tb_range_tracker;

   localparam int CNT_W = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       in_valid;
   logic [3:0] in_data;
   logic [3:0] min_val, max_val, span;
   logic       range_valid, new_min, new_max, cnt_sat;
   logic [CNT_W-1:0] count;

   always #5 clk = ~clk;

   range_tracker #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .min_val     (min_val),
      .max_val     (max_val),
      .span        (span),
      .range_valid (range_valid),
      .new_min     (new_min),
      .new_max     (new_max),
      .count       (count),
      .cnt_sat     (cnt_sat)
   );

   typedef struct packed {
      logic [3:0]       mn;
      logic [3:0]       mx;
      logic [3:0]       sp;
      logic             rv;
      logic             nmn;
      logic             nmx;
      logic [CNT_W-1:0] cnt;
      logic             sat;
   } exp_t;

   typedef struct {
      string nm;
      exp_t  e;
   } item_t;

   item_t q[$];
   int n_cmp = 0;
   int n_bad = 0;

   function automatic exp_t mk(input logic [3:0] mn, input logic [3:0] mx,
                               input logic rv, input logic nmn, input logic nmx,
                               input int cnt, input logic sat);
      exp_t e;
      e.mn  = mn;
      e.mx  = mx;
      e.sp  = mx - mn;
      e.rv  = rv;
      e.nmn = nmn;
      e.nmx = nmx;
      e.cnt = CNT_W'(cnt);
      e.sat = sat;
      return e;
   endfunction

   function automatic exp_t zeros();
      return mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
   endfunction

   task automatic compare(input string nm, input exp_t e);
      exp_t got;
      got = {min_val, max_val, span, range_valid, new_min, new_max, count, cnt_sat};
      n_cmp++;
      if (got !== e) begin
         n_bad++;
         $display("FAIL %s: got min=%0d max=%0d span=%0d rv=%b nmin=%b nmax=%b cnt=%0d sat=%b, want min=%0d max=%0d span=%0d rv=%b nmin=%b nmax=%b cnt=%0d sat=%b",
                  nm, got.mn, got.mx, got.sp, got.rv, got.nmn, got.nmx, got.cnt, got.sat,
                  e.mn, e.mx, e.sp, e.rv, e.nmn, e.nmx, e.cnt, e.sat);
      end else begin
         $display("ok   %s: min=%0d max=%0d span=%0d cnt=%0d", nm, got.mn, got.mx, got.sp, got.cnt);
      end
   endtask

   // Drive one cycle of stimulus and queue the outputs expected after the edge.
   task automatic step(input string nm, input logic c, input logic v,
                       input logic [3:0] d, input exp_t e);
      item_t it;
      @(negedge clk);
      clr      = c;
      in_valid = v;
      in_data  = d;
      it.nm = nm;
      it.e  = e;
      q.push_back(it);
   endtask

   // Monitor: every clock edge the DUT presents a new output set.
   always @(posedge clk) begin
      item_t it;
      #1;
      if (q.size() > 0) begin
         it = q.pop_front();
         compare(it.nm, it.e);
      end
   end

   initial begin
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 4'd0;
      #2;
      compare("reset_hold", zeros());
      @(negedge clk); rst_n = 1'b1;

      step("idle_after_reset", 0, 0, 4'd0, zeros());
      // First sample and typical stream 7,3,12,5,3,12
      step("s1_7",   0, 1, 4'd7,  mk(7, 7,  1, 1, 1, 1, 0));
      step("s2_3",   0, 1, 4'd3,  mk(3, 7,  1, 1, 0, 2, 0));
      step("s3_12",  0, 1, 4'd12, mk(3, 12, 1, 0, 1, 3, 0));
      step("s4_5",   0, 1, 4'd5,  mk(3, 12, 1, 0, 0, 4, 0));
      step("s5_3eq", 0, 1, 4'd3,  mk(3, 12, 1, 0, 0, 5, 0));
      step("s6_12eq",0, 1, 4'd12, mk(3, 12, 1, 0, 0, 6, 0));
      step("idle_hold", 0, 0, 4'd1, mk(3, 12, 1, 0, 0, 6, 0));
      // clr beats in_valid; next sample acts as first
      step("clr_with_valid", 1, 1, 4'd2, zeros());
      step("after_clr_9",    0, 1, 4'd9, mk(9, 9, 1, 1, 1, 1, 0));
      step("clr2",           1, 0, 4'd0, zeros());
      // Extremes 8,0,15,0
      step("x_8",   0, 1, 4'd8,  mk(8, 8,  1, 1, 1, 1, 0));
      step("x_0",   0, 1, 4'd0,  mk(0, 8,  1, 1, 0, 2, 0));
      step("x_15",  0, 1, 4'd15, mk(0, 15, 1, 0, 1, 3, 0));
      step("x_0eq", 0, 1, 4'd0,  mk(0, 15, 1, 0, 0, 4, 0));
      step("clr3",  1, 0, 4'd0, zeros());
      // Saturation with CNT_W=3: 9 samples
      step("c1_5", 0, 1, 4'd5,  mk(5, 5,  1, 1, 1, 1, 0));
      step("c2_6", 0, 1, 4'd6,  mk(5, 6,  1, 0, 1, 2, 0));
      step("c3_4", 0, 1, 4'd4,  mk(4, 6,  1, 1, 0, 3, 0));
      step("c4_5", 0, 1, 4'd5,  mk(4, 6,  1, 0, 0, 4, 0));
      step("c5_5", 0, 1, 4'd5,  mk(4, 6,  1, 0, 0, 5, 0));
      step("c6_5", 0, 1, 4'd5,  mk(4, 6,  1, 0, 0, 6, 0));
      step("c7_5_sat", 0, 1, 4'd5, mk(4, 6, 1, 0, 0, 7, 1));
      step("c8_2",  0, 1, 4'd2,  mk(2, 6,  1, 1, 0, 7, 1));
      step("c9_14", 0, 1, 4'd14, mk(2, 14, 1, 0, 1, 7, 1));
      step("c_idle", 0, 0, 4'd0, mk(2, 14, 1, 0, 0, 7, 1));
      // Async reset mid-stream
      step("clr4",  1, 0, 4'd0, zeros());
      step("r1_10", 0, 1, 4'd10, mk(10, 10, 1, 1, 1, 1, 0));
      step("r2_11", 0, 1, 4'd11, mk(10, 11, 1, 0, 1, 2, 0));
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      compare("async_reset_immediate", zeros());
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = (i % 2 == 0);
         in_data  = 4'(i + 1);
         clr      = 1'b0;
      end
      #1;
      compare("async_reset_held", zeros());
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      step("post_reset_9", 0, 1, 4'd9, mk(9, 9, 1, 1, 1, 1, 0));
      step("post_reset_idle", 0, 0, 4'd0, mk(9, 9, 1, 0, 0, 1, 0));

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      #2;
      if (q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d entries left, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_range_tracker
